// File: rtl/sg_elem_requester.sv
// rtl/sg_elem_requester.sv - splits SG elements into size-bounded PCIe read requests under tag credits
// Define SG_REQ_4K_SPLIT_EN to also cut requests at 4 KB address boundaries.
module sg_elem_requester #(
  parameter int C_MAX_READ_REQ = 2,
  parameter int C_MAX_TAGS     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE,
  input  logic        XFER_START,
  input  logic [31:0] XFER_LEN,
  output logic        XFER_REQ_DONE,
  input  logic [63:0] SG_ELEM_ADDR,
  input  logic [31:0] SG_ELEM_LEN,
  input  logic        SG_ELEM_RDY,
  output logic        SG_ELEM_REN,
  output logic        RX_REQ,
  input  logic        RX_REQ_ACK,
  output logic [1:0]  RX_REQ_TAG,
  output logic [63:0] RX_REQ_ADDR,
  output logic [9:0]  RX_REQ_LEN,
  input  logic        TAG_FREE
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] MAX_CODE = 3'(C_MAX_READ_REQ);
  localparam logic [2:0] MAX_TAGS = 3'(C_MAX_TAGS);

  logic [2:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] elem_rem_q, elem_rem_d;
  logic [31:0] xfer_rem_q, xfer_rem_d;
  logic [10:0] max_words_q, max_words_d;
  logic [10:0] len_q, len_d;
  logic [1:0]  tag_q, tag_d;
  logic [2:0]  outstanding_q, outstanding_d;

  logic [2:0]  size_code;
  logic [10:0] bound_len;
  logic        rx_req;
  logic        ack_fire;

  assign size_code = (CONFIG_MAX_READ_REQUEST_SIZE < MAX_CODE) ? CONFIG_MAX_READ_REQUEST_SIZE : MAX_CODE;
  assign rx_req    = (state_q == S_REQ) && (outstanding_q < MAX_TAGS);
  assign ack_fire  = rx_req && RX_REQ_ACK;

  // Next request length: smallest of the remaining element, remaining transfer, size cap and page room.
  always_comb begin
    bound_len = max_words_q;
    if (xfer_rem_q < {21'd0, bound_len}) bound_len = xfer_rem_q[10:0];
    if (elem_rem_q < {21'd0, bound_len}) bound_len = elem_rem_q[10:0];
`ifdef SG_REQ_4K_SPLIT_EN
    if ((11'h400 - {1'b0, addr_q[11:2]}) < bound_len) bound_len = 11'h400 - {1'b0, addr_q[11:2]};
`endif
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    elem_rem_d    = elem_rem_q;
    xfer_rem_d    = xfer_rem_q;
    max_words_d   = max_words_q;
    len_d         = len_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q;
    case (state_q)
      S_IDLE: begin
        if (XFER_START) begin
          xfer_rem_d  = XFER_LEN;
          max_words_d = 11'd32 << size_code;
          state_d     = (XFER_LEN == 32'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (SG_ELEM_RDY) begin
          addr_d     = {SG_ELEM_ADDR[63:2], 2'b00};
          elem_rem_d = SG_ELEM_LEN;
          state_d    = (SG_ELEM_LEN == 32'd0) ? S_FETCH : S_CALC;
        end
      end
      S_CALC: begin
        len_d   = bound_len;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ack_fire) begin
          addr_d     = addr_q + {51'd0, len_q, 2'b00};
          elem_rem_d = elem_rem_q - {21'd0, len_q};
          xfer_rem_d = xfer_rem_q - {21'd0, len_q};
          tag_d      = tag_q + 2'd1;
          // Any element leftover is dropped once the transfer is satisfied.
          if (xfer_rem_d == 32'd0)      state_d = S_DONE;
          else if (elem_rem_d == 32'd0) state_d = S_FETCH;
          else                          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ack_fire && !TAG_FREE)
      outstanding_d = outstanding_q + 3'd1;
    else if (!ack_fire && TAG_FREE && (outstanding_q != 3'd0))
      outstanding_d = outstanding_q - 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      elem_rem_q    <= '0;
      xfer_rem_q    <= '0;
      max_words_q   <= '0;
      len_q         <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      elem_rem_q    <= elem_rem_d;
      xfer_rem_q    <= xfer_rem_d;
      max_words_q   <= max_words_d;
      len_q         <= len_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign XFER_REQ_DONE = (state_q == S_DONE);
  assign SG_ELEM_REN   = (state_q == S_FETCH) && SG_ELEM_RDY;
  assign RX_REQ        = rx_req;
  assign RX_REQ_TAG    = tag_q;
  assign RX_REQ_ADDR   = addr_q;
  assign RX_REQ_LEN    = len_q[9:0];
endmodule

// File: tb/tb_sg_elem_requester.sv
// tb/tb_sg_elem_requester.sv - randomized self-checking bench for sg_elem_requester
module tb_sg_elem_requester;
  localparam int MAX_CODE = 2;
  localparam int MAX_TAGS = 4;
`ifdef SG_REQ_4K_SPLIT_EN
  localparam int T2_FIRST_LEN = 32;
`else
  localparam int T2_FIRST_LEN = 64;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE = '0;
  logic        XFER_START = 1'b0;
  logic [31:0] XFER_LEN = '0;
  logic        XFER_REQ_DONE;
  logic [63:0] SG_ELEM_ADDR = '0;
  logic [31:0] SG_ELEM_LEN = '0;
  logic        SG_ELEM_RDY = 1'b0;
  logic        SG_ELEM_REN;
  logic        RX_REQ;
  logic        RX_REQ_ACK = 1'b0;
  logic [1:0]  RX_REQ_TAG;
  logic [63:0] RX_REQ_ADDR;
  logic [9:0]  RX_REQ_LEN;
  logic        TAG_FREE = 1'b0;

  sg_elem_requester #(.C_MAX_READ_REQ(MAX_CODE), .C_MAX_TAGS(MAX_TAGS)) dut (
    .CLK(CLK), .RST(RST),
    .CONFIG_MAX_READ_REQUEST_SIZE(CONFIG_MAX_READ_REQUEST_SIZE),
    .XFER_START(XFER_START), .XFER_LEN(XFER_LEN), .XFER_REQ_DONE(XFER_REQ_DONE),
    .SG_ELEM_ADDR(SG_ELEM_ADDR), .SG_ELEM_LEN(SG_ELEM_LEN),
    .SG_ELEM_RDY(SG_ELEM_RDY), .SG_ELEM_REN(SG_ELEM_REN),
    .RX_REQ(RX_REQ), .RX_REQ_ACK(RX_REQ_ACK), .RX_REQ_TAG(RX_REQ_TAG),
    .RX_REQ_ADDR(RX_REQ_ADDR), .RX_REQ_LEN(RX_REQ_LEN), .TAG_FREE(TAG_FREE)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] addr; logic [31:0] len; } elem_t;
  typedef struct { logic [63:0] addr; int len; } req_t;

  elem_t elems[$];
  req_t  exp_q[$];
  int    fire_cyc[$];
  int    fire_len[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    eidx, ren_cnt, exp_ren, fires, done_seen, last_fire_cyc, last_ren_cyc;
  int    first_ren_cyc, first_req_gap, start_cyc;
  int    m_out = 0;
  logic [1:0] m_tag = '0;
  int    p_rdy, p_ack, p_free;
  logic  start_pend = 1'b0;
  logic  free_force = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the element list with plain arithmetic and list every request the transfer needs.
  task automatic build_expect(input longint unsigned xlen, input int cfg);
    longint unsigned rem, a, l, r, mw;
    int code;
    rem  = xlen;
    code = (cfg < MAX_CODE) ? cfg : MAX_CODE;
    mw   = 64'd32 << code;
    exp_q.delete();
    exp_ren = 0;
    for (int i = 0; i < elems.size() && rem > 0; i++) begin
      exp_ren++;
      a = elems[i].addr & ~64'h3;
      l = elems[i].len;
      while (l > 0 && rem > 0) begin
        r = mw;
        if (l < r) r = l;
        if (rem < r) r = rem;
`ifdef SG_REQ_4K_SPLIT_EN
        begin
          longint unsigned pg;
          pg = (64'd4096 - (a % 64'd4096)) / 64'd4;
          if (pg < r) r = pg;
        end
`endif
        exp_q.push_back('{a, int'(r)});
        a   = a + r * 64'd4;
        l   = l - r;
        rem = rem - r;
      end
    end
  endtask

  task automatic step();
    logic fire;
    req_t e;
    @(negedge CLK);
    XFER_START = start_pend;
    start_pend = 1'b0;
    if (eidx < elems.size()) begin
      SG_ELEM_ADDR = elems[eidx].addr;
      SG_ELEM_LEN  = elems[eidx].len;
      SG_ELEM_RDY  = ($urandom_range(99) < p_rdy);
    end else begin
      SG_ELEM_ADDR = {$urandom, $urandom};
      SG_ELEM_LEN  = $urandom;
      SG_ELEM_RDY  = 1'b0;
    end
    RX_REQ_ACK = ($urandom_range(99) < p_ack);
    TAG_FREE   = free_force || ($urandom_range(99) < p_free);
    free_force = 1'b0;
    #1;
    cyc++;
    if (SG_ELEM_REN) begin
      check("ren_without_rdy", SG_ELEM_RDY, 1);
      if (ren_cnt == 0) first_ren_cyc = cyc;
      ren_cnt++;
      eidx++;
      last_ren_cyc = cyc;
    end
    if (m_out >= MAX_TAGS) check("req_over_credit", RX_REQ, 0);
    if (RX_REQ && first_req_gap < 0) first_req_gap = cyc - last_ren_cyc;
    fire = RX_REQ && RX_REQ_ACK;
    if (fire) begin
      if (exp_q.size() == 0) check("req_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("req_addr", RX_REQ_ADDR, e.addr);
        check("req_len", RX_REQ_LEN, e.len[9:0]);
        check("req_tag", RX_REQ_TAG, m_tag);
      end
      m_tag++;
      fires++;
      fire_cyc.push_back(cyc);
      fire_len.push_back(int'(RX_REQ_LEN));
      last_fire_cyc = cyc;
    end
    if (fire && !TAG_FREE) m_out++;
    else if (!fire && TAG_FREE && m_out > 0) m_out--;
    if (XFER_REQ_DONE) begin
      done_seen++;
      check("done_reqs_left", exp_q.size(), 0);
      check("done_ren_count", ren_cnt, exp_ren);
      if (fires > 0) check("done_latency", cyc - last_fire_cyc, 1);
    end
  endtask

  task automatic begin_xfer(input logic [31:0] xlen, input logic [2:0] cfg);
    XFER_LEN = xlen;
    CONFIG_MAX_READ_REQUEST_SIZE = cfg;
    build_expect(xlen, cfg);
    eidx = 0; ren_cnt = 0; fires = 0; done_seen = 0;
    first_ren_cyc = -1; first_req_gap = -1; last_ren_cyc = 0;
    fire_cyc.delete();
    fire_len.delete();
    start_pend = 1'b1;
    start_cyc  = cyc + 1;
  endtask

  task automatic run_xfer(input logic [31:0] xlen, input logic [2:0] cfg, input bit exact, input int budget);
    begin_xfer(xlen, cfg);
    for (int i = 0; i < budget && done_seen == 0; i++) step();
    check("xfer_done_pulse", done_seen, 1);
    if (exact && xlen != 0) begin
      check("start_to_ren", first_ren_cyc - start_cyc, 1);
      check("ren_to_req", first_req_gap, 2);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ctrl"}, {XFER_REQ_DONE, SG_ELEM_REN, RX_REQ, RX_REQ_TAG}, 0);
    check({pfx, "_addr"}, RX_REQ_ADDR, 0);
    check({pfx, "_len"}, RX_REQ_LEN, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; XFER_START = 1'b0; SG_ELEM_RDY = 1'b0; RX_REQ_ACK = 1'b0; TAG_FREE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    m_out = 0; m_tag = '0;
    exp_q.delete();
    elems.delete();
    eidx = 0; done_seen = 0;
  endtask

  task automatic make_elems(input logic [31:0] xlen);
    longint unsigned sum;
    logic [63:0] a;
    logic [31:0] l;
    sum = 0;
    elems.delete();
    while (sum < xlen || elems.size() == 0) begin
      case ($urandom_range(2))
        0:       a = {$urandom, $urandom};
        1:       a = 64'h1000 * $urandom_range(1, 15) - 64'(4 * $urandom_range(0, 64)) + 64'($urandom_range(3));
        default: a = 64'hFFFF_F000 + 64'($urandom_range(4095));
      endcase
      l = ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
      elems.push_back('{a, l});
      sum += l;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p_rdy = 100; p_ack = 100; p_free = 0;
    do_reset();
    #1;
    check_zero("reset");

    // Page-aligned element split by the 512B cap.
    do_reset();
    elems.push_back('{64'h1000, 32'd256});
    run_xfer(256, 3'b010, 1'b1, 100);
    check("t1_fires", fires, 2);
    if (fire_cyc.size() >= 2) check("t1_b2b_gap", fire_cyc[1] - fire_cyc[0], 2);

    // Element straddling a 4 KB boundary.
    do_reset();
    elems.push_back('{64'h1F80, 32'd64});
    run_xfer(64, 3'b010, 1'b1, 100);
    if (fire_len.size() >= 1) check("t2_first_len", fire_len[0], T2_FIRST_LEN);

    // Zero-length element skipped, long element truncated by the transfer.
    do_reset();
    elems.push_back('{64'h0, 32'd0});
    elems.push_back('{64'h100, 32'd50});
    run_xfer(10, 3'b010, 1'b1, 100);
    check("t3_ren", ren_cnt, 2);
    check("t3_fires", fires, 1);

    // Credit stall with no completions, then one credit returned.
    do_reset();
    elems.push_back('{64'h0, 32'd1024});
    begin_xfer(1024, 3'b000);
    repeat (20) step();
    check("t4_fires_stalled", fires, 4);
    check("t4_req_low", RX_REQ, 0);
    free_force = 1'b1;
    step();
    step();
    check("t4_req_release", RX_REQ, 1);
    check("t4_fifth_fire", fires, 5);
    p_free = 50;
    for (int i = 0; i < 3000 && done_seen == 0; i++) step();
    check("t4_done", done_seen, 1);
    p_free = 0;

    // Element chain, then the same transfer abandoned by reset.
    do_reset();
    elems.push_back('{64'h0, 32'd32});
    elems.push_back('{64'h4000, 32'd32});
    run_xfer(64, 3'b010, 1'b1, 100);
    check("t5_fires", fires, 2);
    check("t5_ren", ren_cnt, 2);
    do_reset();
    elems.push_back('{64'h0, 32'd32});
    elems.push_back('{64'h4000, 32'd32});
    p_ack = 0;
    begin_xfer(64, 3'b010);
    for (int i = 0; i < 20 && !RX_REQ; i++) step();
    check("t5_in_req", RX_REQ, 1);
    @(negedge CLK);
    RST = 1'b1; RX_REQ_ACK = 1'b0; SG_ELEM_RDY = 1'b0;
    @(posedge CLK);
    #1;
    check_zero("mid_reset");
    @(negedge CLK);
    RST = 1'b0;
    m_out = 0; m_tag = '0;
    exp_q.delete();
    elems.delete();
    eidx = 0; done_seen = 0;
    repeat (10) step();
    check("t5_no_done", done_seen, 0);

    // Randomized transfers; tag and credit state carry over between them.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] xlen;
      p_rdy  = $urandom_range(40, 100);
      p_ack  = $urandom_range(30, 100);
      p_free = $urandom_range(20, 70);
      xlen   = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
      make_elems(xlen);
      run_xfer(xlen, 3'($urandom_range(7)), 1'b0, 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
